// File: rtl/kingdom_pkg.sv
// kingdom_pkg: shared Lucas seeds, default widths and sequencer state encoding
package kingdom_pkg;
    localparam int DEF_WIDTH = 64;
    localparam int DEF_IDX_W = 8;
    localparam int LUCAS_L0 = 2;
    localparam int LUCAS_L1 = 1;
    localparam int LUCAS_10_EXPECTED = 123;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
endpackage

// File: rtl/kingdom_lucas_sequencer_if.sv
// kingdom_lucas_sequencer_if: valid/ready term stream out of the Lucas sequencer
interface kingdom_lucas_sequencer_if
    import kingdom_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
);
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_index;
    logic             out_valid;
    logic             out_ready;
    modport master (output out_data, out_index, out_valid, input out_ready);
    modport slave  (input out_data, out_index, out_valid, output out_ready);
endinterface

// File: rtl/kingdom_lucas_step.sv
// kingdom_lucas_step: one Lucas recurrence step, kept separate so it can be pipelined later
module kingdom_lucas_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    assign {carry, sum} = {1'b0, prev} + {1'b0, cur};
endmodule

// File: rtl/kingdom_lucas_sequencer.sv
// kingdom_lucas_sequencer: streams Lucas terms and checks L(CHECK_INDEX) against lucas_ref
module kingdom_lucas_sequencer
    import kingdom_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int CHECK_INDEX = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IDX_W-1:0]          n_count,
    input  logic [WIDTH-1:0]          lucas_ref,
    kingdom_lucas_sequencer_if.master os,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      check_pass,
    output logic                      check_fail
);
    state_t           state;
    logic [IDX_W-1:0] cnt, idx;
    logic [WIDTH-1:0] prev, cur, sum, nxt;
    logic             carry, vld, nc, hs, last;

    kingdom_lucas_step #(.WIDTH(WIDTH)) u_step (.prev(prev), .cur(cur), .sum(sum), .carry(carry));

    // L(-1) does not exist, so the step out of index 0 is forced to L(1)
    assign nxt  = idx == '0 ? WIDTH'(LUCAS_L1) : sum;
    assign nc   = idx != '0 && carry;
    assign hs   = vld && os.out_ready;
    assign last = idx == cnt - IDX_W'(1);

    assign os.out_data  = cur;
    assign os.out_index = idx;
    assign os.out_valid = vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            prev       <= '0;
            cur        <= '0;
            vld        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            check_pass <= 1'b0;
            check_fail <= 1'b0;
        end else begin
            done <= state == FINISH;
            case (state)
                IDLE: if (start) begin
                    cnt        <= n_count;
                    overflow   <= 1'b0;
                    check_pass <= 1'b0;
                    check_fail <= 1'b0;
                    if (n_count == '0) state <= FINISH;
                    else begin
                        state <= RUN;
                        cur   <= WIDTH'(LUCAS_L0);
                        prev  <= '0;
                        idx   <= '0;
                        vld   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                RUN: if (hs) begin
                    if (idx == IDX_W'(CHECK_INDEX)) begin
                        check_pass <= cur == lucas_ref;
                        check_fail <= cur != lucas_ref;
                    end
                    // an overflowing successor is dropped rather than emitted truncated
                    if (last || nc) begin
                        overflow <= nc && !last;
                        vld      <= 1'b0;
                        busy     <= 1'b0;
                        state    <= FINISH;
                    end else begin
                        prev <= cur;
                        cur  <= nxt;
                        idx  <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kingdom_lucas_sequencer.sv
// tb_kingdom_lucas_sequencer: directed runs with a term scoreboard and handshake stall checks
module tb_kingdom_lucas_sequencer;
    import kingdom_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [7:0]  n_count;
    logic [63:0] lucas_ref;
    logic        busy, done, overflow, check_pass, check_fail;
    int          checks = 0;
    int          fails = 0;
    logic [71:0] sb[$];

    kingdom_lucas_sequencer_if #(.WIDTH(64), .IDX_W(8)) bus ();
    assign bus.out_ready = out_ready;

    kingdom_lucas_sequencer #(.WIDTH(64), .IDX_W(8), .CHECK_INDEX(10)) dut (
        .clk(clk), .rst(rst), .start(start), .n_count(n_count), .lucas_ref(lucas_ref),
        .os(bus), .busy(busy), .done(done), .overflow(overflow),
        .check_pass(check_pass), .check_fail(check_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // model pushes expected terms, then the DUT stream is popped and compared at each handshake
    task automatic run(input int n, input logic [63:0] lref, input bit stall, input bit poke,
                       output logic [63:0] ld, output logic [7:0] li);
        logic [64:0] s;
        logic [63:0] p, c, t, l10, sd;
        logic [71:0] e;
        logic [7:0]  si;
        int          emitted;
        bit          eovf, st, seen;
        p = 0; c = 0; l10 = 0; emitted = 0; eovf = 0; ld = 0; li = 0;
        for (int i = 0; i < n; i++) begin
            if (i < 2) t = (i == 0) ? 64'd2 : 64'd1;
            else begin
                s = {1'b0, c} + {1'b0, p};
                if (s[64]) begin eovf = 1; break; end
                t = s[63:0];
            end
            p = c; c = t;
            if (i == 10) l10 = t;
            sb.push_back({8'(i), t});
            emitted++;
        end
        lucas_ref = lref;
        @(negedge clk); start = 1'b1; n_count = 8'(n);
        @(negedge clk); start = 1'b0; n_count = 8'($urandom);
        st = 0; seen = 0; sd = 0; si = 0;
        for (int cyc = 1; cyc < 300 && !seen; cyc++) begin
            out_ready = stall ? ((cyc - 1) % 4 == 0 || (cyc - 1) % 4 == 3) : 1'b1;
            start = poke && cyc == 4;
            if (cyc == 1) begin
                chk("first_valid", bus.out_valid, n != 0);
                chk("busy_run", busy, n != 0);
            end
            if (st) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, sd);
                chk("stall_index", bus.out_index, si);
            end
            st = bus.out_valid && !out_ready; sd = bus.out_data; si = bus.out_index;
            if (bus.out_valid && out_ready) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("term_index", bus.out_index, e[71:64]);
                    chk("term_data", bus.out_data, e[63:0]);
                end
                ld = bus.out_data; li = bus.out_index;
            end
            if (done) begin
                seen = 1;
                if (n == 0) chk("done_latency", cyc, 2);
            end else @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        chk("busy_end", busy, 0);
        chk("valid_end", bus.out_valid, 0);
        chk("overflow", overflow, eovf);
        chk("check_pass", check_pass, emitted > 10 && l10 == lref);
        chk("check_fail", check_fail, emitted > 10 && l10 != lref);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        logic [63:0] ld;
        logic [7:0]  li;
        bit          hit;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; n_count = 8'd0;
        lucas_ref = 64'(LUCAS_10_EXPECTED);
        @(negedge clk);
        chk("rst_data", bus.out_data, 0);
        chk("rst_index", bus.out_index, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_flags", {busy, done, overflow, check_pass, check_fail}, 0);
        rst = 1'b0;
        run(11, 64'd123, 0, 0, ld, li);
        chk("l10_value", ld, 64'd123);
        run(11, 64'd124, 0, 0, ld, li);
        chk("l10_index", li, 10);
        run(11, 64'd123, 1, 0, ld, li);
        run(100, 64'd123, 0, 0, ld, li);
        chk("last_index", li, 92);
        chk("last_data", ld, 64'd16860207025497407047);
        run(0, 64'd123, 0, 0, ld, li);
        run(5, 64'd123, 0, 0, ld, li);
        chk("n5_last_index", li, 4);
        run(11, 64'd123, 0, 1, ld, li);
        chk("poke_last_index", li, 10);
        lucas_ref = 64'd123; out_ready = 1'b1;
        @(negedge clk); start = 1'b1; n_count = 8'd11;
        @(negedge clk); start = 1'b0;
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (bus.out_valid && bus.out_index == 8'd6) hit = 1;
            else @(negedge clk);
        end
        chk("reach_index6", hit, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", bus.out_data, 0);
        chk("async_rst_index", bus.out_index, 0);
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_flags", {busy, done, overflow, check_pass, check_fail}, 0);
        @(negedge clk); rst = 1'b0;
        run(5, 64'd123, 0, 0, ld, li);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/kingdom_lucas_sequencer.md
Name: kingdom_lucas_sequencer

Overview:
- Sequential generator for Lucas numbers L(0)=2, L(1)=1, L(n)=L(n-1)+L(n-2). Sits directly downstream of the kingdom constants block.
- Consumes that block's lucas_10 word and self-checks the generated L(10) against it in hardware. This replaces the stubbed "always 1" identity check with a real one.
- Streams terms to downstream consumers over a valid/ready interface.

Parameters:
- WIDTH, 64, bit width of each term and of lucas_ref.
- IDX_W, 8, width of the term count and index.
- CHECK_INDEX, 10, index of the term compared against lucas_ref.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a sequence run; sampled only in IDLE.
- n_count  in  IDX_W  number of terms to emit; latched on accepted start.
- lucas_ref  in  WIDTH  expected L(CHECK_INDEX); wired to the constants block lucas_10 (64'd123).
- out_data  out  WIDTH  current term L(out_index).
- out_index  out  IDX_W  index of current term.
- out_valid  out  1  term on out_data/out_index is valid.
- out_ready  in  1  downstream accepts the term when out_valid && out_ready.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run ends.
- overflow  out  1  sticky; next term exceeded WIDTH bits.
- check_pass  out  1  sticky; L(CHECK_INDEX) equalled lucas_ref.
- check_fail  out  1  sticky; L(CHECK_INDEX) differed from lucas_ref.

Behaviour:
- Reset (async, any state): state=IDLE; out_data=0, out_index=0, out_valid=0, busy=0, done=0, overflow=0, check_pass=0, check_fail=0. A run in progress is abandoned; no partial done.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 latches n_count and clears overflow, check_pass and check_fail.
  - If n_count=0: go to FINISH, no output.
  - Otherwise go to RUN with out_data=2, out_index=0, out_valid=1 on the next cycle. Latency from start to first valid term is 1 cycle.
- RUN:
  - Registers prev/cur hold L(i-1) and L(i).
  - On handshake (out_valid && out_ready):
    - If out_index == n_count-1, go to FINISH with out_valid=0.
    - Else compute next = cur + prev at WIDTH+1 bits, with index 0→1 special-cased to 1.
    - If the carry bit is set: overflow=1, out_valid=0, go to FINISH; the overflowed term is never emitted.
    - Else out_data=next, out_index+1, out_valid stays 1.
  - Throughput is 1 term per cycle while out_ready=1.
  - While out_valid=1 && out_ready=0, out_data and out_index are held stable. This is an AXI-style valid: it never drops without a handshake.
- Self-check:
  - On the handshake of the term with out_index == CHECK_INDEX: set check_pass if out_data == lucas_ref, else set check_fail.
  - Exactly one of the two flags sets per run, and only if that term is emitted.
  - A run ending before CHECK_INDEX leaves both flags 0.
- FINISH: done=1 for one cycle, then IDLE. Sticky flags hold until the next accepted start or reset.
- start outside IDLE is ignored; n_count changes after latch are ignored.
- Widths: the IDX_W index counter does not wrap. n_count ≤ 2^IDX_W-1 bounds it.
- WIDTH=64 boundary: L(92)=16860207025497407047 is the last representable term; L(93) sets overflow.

Decomposition:
- Shared package kingdom_pkg:
  - LUCAS_L0=2, LUCAS_L1=1, LUCAS_10_EXPECTED=123.
  - State enum {IDLE, RUN, FINISH}.
  - Default widths (WIDTH=64, IDX_W=8).
- One sub-module, kingdom_lucas_step: combinational WIDTH-bit adder producing next and carry from prev/cur. It is isolated so a pipelined adder can replace it later.
- FSM, handshake and check logic stay in the top.

Test Plan:
- Reset then start, n_count=11, out_ready=1, lucas_ref=123:
  - Terms are 2,1,3,4,7,11,18,29,47,76,123 on indices 0..10, one per cycle, first valid 1 cycle after start.
  - check_pass=1, check_fail=0, done pulses once, overflow=0.
- Same run with lucas_ref=124 → check_fail=1, check_pass=0, all 11 terms still emitted.
- n_count=11, out_ready toggling 1,0,0,1 pattern:
  - out_data/out_index stable during every stall.
  - Same 11-term sequence, no duplicates or skips.
- n_count=100, out_ready=1:
  - Last emitted term is index 92 = 16860207025497407047.
  - overflow=1, done pulses, no index 93 term.
  - check_pass=1.
- Boundary cases:
  - n_count=0 → done 2 cycles after start, out_valid never asserts.
  - n_count=5 → indices 0..4 only, both check flags 0.
  - start pulsed during RUN is ignored.
- Assert rst mid-RUN at index 6 → all outputs 0 immediately (asynchronously). A fresh start then restarts at L(0)=2 with flags cleared.
